mem_sram_slave: RTL and testbench
=================================

Name: mem_sram_slave

Overview:
- Memory-side slave for the single merged processor memory port. Consumes the arbitrated instruction/data request stream: request strobe, write enable, address, write data and byte strobes.
- Backed by a word-organised on-chip array.
- Provides the accept handshake (mem_valid), optional programmable wait states, and an in-order read-response pipeline of fixed latency (mem_rresp/mem_rdata).
- Used as the simulation memory and the FPGA block-RAM front end.

Parameters:
- AW, 16: log2 of array depth in 32-bit words (array = 2^AW words).
- RD_LAT, 1: cycles from read handshake to mem_rresp; legal range 1..8.
- WAIT_CYC, 0: wait cycles inserted before each request is accepted; legal range 0..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetb  in  1  synchronous active-low reset.
- mem_ready  in  1  requester has a valid request on mem_we/mem_addr/mem_wdata/mem_wstrb.
- mem_valid  out  1  slave accepts the request this cycle; handshake = mem_ready && mem_valid.
- mem_we  in  1  1 = write, 0 = read; qualified by mem_ready.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  write data.
- mem_wstrb  in  4  byte enables for writes; bit i enables byte lane [8i+7:8i].
- mem_rresp  out  1  one-cycle pulse; mem_rdata carries a read response.
- mem_rdata  out  32  read data.
- mem_err  out  1  sticky flag: an out-of-range access was accepted.

Behaviour:
- Reset (resetb low at a clk edge): mem_rresp=0, mem_rdata=0, mem_err=0, wait counter wcnt=WAIT_CYC, read pipeline flushed.
  - Array contents are not cleared.
  - Reset mid-operation drops every outstanding read; no mem_rresp is issued for it afterwards.
- Accept logic:
  - mem_valid = mem_ready && (wcnt==0), combinational.
  - The requester's arbiter samples mem_valid in the same cycle. With WAIT_CYC=0, mem_valid follows mem_ready.
  - Wait counter per cycle:
    - mem_ready && wcnt!=0: wcnt decrements.
    - On a handshake: wcnt reloads to WAIT_CYC.
    - mem_ready low: wcnt holds. A partially counted wait is not restarted if the requester drops and re-asserts.
  - So with mem_ready held high continuously, the first handshake occurs on cycle WAIT_CYC (0-based) and every WAIT_CYC+1 cycles after that.
  - At most one handshake per cycle.
- Address decode:
  - Word index = mem_addr[AW+1:2]. mem_addr[1:0] is ignored.
  - Out of range if mem_addr[31:AW+2] != 0.
- Write (handshake with mem_we=1):
  - In range: at the same edge, each byte lane with mem_wstrb[i]=1 is written; other lanes keep their value. mem_wstrb=0 is a legal no-op write that still handshakes.
  - Writes produce no mem_rresp.
- Read (handshake with mem_we=0):
  - The array word is captured at the handshake edge into pipeline stage 1.
  - mem_rresp is asserted, with mem_rdata valid, exactly RD_LAT cycles after the handshake cycle. For RD_LAT=1 it is the cycle immediately after.
  - Reads are returned in order. The pipeline is RD_LAT stages of {valid, data}, so back-to-back reads give back-to-back responses and no overflow is possible.
  - mem_rdata holds its last value when mem_rresp=0.
- Read-after-write: a read accepted the cycle after a write to the same word returns the new data. A read and a write can never be accepted in the same cycle.
- Out-of-range access:
  - Write is dropped.
  - Read still handshakes and still produces mem_rresp, with mem_rdata=0.
  - mem_err is set at the handshake edge and stays 1 until reset.
- The requester may change mem_addr/mem_we while mem_valid=0. The slave samples the request only on the handshake edge.
- Inputs are registered internally only on handshake. There are no combinational paths from mem_addr/mem_we to mem_valid.

Test Plan:
- AW=16, RD_LAT=1, WAIT_CYC=0: write 0xDEADBEEF to 0x100 with wstrb=0xF, then read 0x100 -> mem_valid in the request cycle; mem_rresp=1 and mem_rdata=0xDEADBEEF the next cycle.
- Write 0x00000000 to 0x0, then write 0x11223344 to 0x0 with wstrb=0b0101 and read 0x0 -> 0x00220044. Read 0x3 -> same word 0x00220044.
- WAIT_CYC=2, mem_ready held high from cycle 0 on a read of 0x100 -> mem_valid=0 on cycles 0–1 and 1 on cycle 2. Next request accepted at cycle 5. mem_ready dropped at cycle 1 and raised at cycle 3 -> accept at cycle 4.
- RD_LAT=3: reads of 0x0, 0x4, 0x8 on consecutive cycles 0,1,2 (preloaded 1,2,3) -> mem_rresp high on cycles 3,4,5 with data 1,2,3. A write at 0x8 on cycle 3 does not change the cycle-5 response (3).
- AW=10: read 0x00001000 -> handshake; mem_rresp with mem_rdata=0; mem_err=1 and stays 1. Write 0x55 to 0x00001000 is dropped: a read of 0x0 still returns the prior value.
- RD_LAT=2: read accepted at cycle 0, resetb low at cycle 1 -> no mem_rresp on cycles 2–3, mem_rdata=0, wcnt reloaded. A write made before the reset is still readable afterwards.

Source files
------------

// File: rtl/mem_sram_slave_if.sv
// Merged processor memory port: request/accept handshake plus read response.
interface mem_sram_slave_if;
    logic        mem_ready;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rresp;
    logic [31:0] mem_rdata;
    logic        mem_err;

    modport master (
        output mem_ready, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_valid, mem_rresp, mem_rdata, mem_err
    );

    modport slave (
        input  mem_ready, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_valid, mem_rresp, mem_rdata, mem_err
    );
endinterface

// File: rtl/mem_sram_slave.sv
// Word-organised on-chip SRAM behind the merged processor memory port.
// Accepts one request per handshake after an optional number of wait
// cycles and returns reads in order through a fixed-latency pipeline.
module mem_sram_slave #(
    parameter int AW       = 16,
    parameter int RD_LAT   = 1,
    parameter int WAIT_CYC = 0
) (
    input logic             clk,
    input logic             resetb,
    mem_sram_slave_if.slave mem
);
    localparam int          DEPTH       = 1 << AW;
    localparam logic [3:0]  WAIT_RELOAD = 4'(WAIT_CYC);

    // Storage array; contents survive reset.
    logic [31:0] mem_q [DEPTH];

    // Wait-state counter and sticky range error.
    logic [3:0]  wcnt_q, wcnt_d;
    logic        err_q, err_d;

    // Read pipeline: RD_LAT stages of {valid, data}; the last stage drives the port.
    logic        vld_q [RD_LAT];
    logic [31:0] dat_q [RD_LAT];
    logic        vld_d [RD_LAT];
    logic [31:0] dat_d [RD_LAT];

    logic          hs;
    logic          wr_hs;
    logic          rd_hs;
    logic          oor;
    logic [AW-1:0] idx;
    logic [31:0]   rd_word;
    logic          unused_addr_lsb;

    // Byte address to word index; anything above the array is out of range.
    assign idx             = mem.mem_addr[AW+1:2];
    assign oor             = |mem.mem_addr[31:AW+2];
    assign unused_addr_lsb = ^mem.mem_addr[1:0];

    // Accept depends only on the requester strobe and the wait counter,
    // never on address or direction.
    assign mem.mem_valid = mem.mem_ready && (wcnt_q == 4'd0);
    assign hs            = mem.mem_valid;
    assign wr_hs         = hs && mem.mem_we && !oor;
    assign rd_hs         = hs && !mem.mem_we;

    // Out-of-range reads still respond, with zero data.
    assign rd_word = oor ? 32'd0 : mem_q[idx];

    assign mem.mem_rresp = vld_q[RD_LAT-1];
    assign mem.mem_rdata = dat_q[RD_LAT-1];
    assign mem.mem_err   = err_q;

    // Next-state for the wait counter and error flag.
    always_comb begin
        wcnt_d = wcnt_q;
        err_d  = err_q;
        if (hs) begin
            // Reload on every accepted request so each one pays the full wait.
            wcnt_d = WAIT_RELOAD;
            if (oor) begin
                err_d = 1'b1;
            end
        end else if (mem.mem_ready && (wcnt_q != 4'd0)) begin
            // Only count while a request is pending; an idle requester
            // keeps whatever wait it has already served.
            wcnt_d = wcnt_q - 4'd1;
        end
    end

    // Control registers: wait counter and sticky error.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            wcnt_q <= WAIT_RELOAD;
            err_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            err_q  <= err_d;
        end
    end

    // Byte-lane writes into the array on an in-range write handshake.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_hs && mem.mem_wstrb[b]) begin
                mem_q[idx][8*b +: 8] <= mem.mem_wdata[8*b +: 8];
            end
        end
    end

    // Stage inputs: stage 0 takes the array word at the read handshake,
    // later stages shift the previous stage along.
    always_comb begin
        for (int i = 0; i < RD_LAT; i++) begin
            vld_d[i] = 1'b0;
            dat_d[i] = 32'd0;
        end
        vld_d[0] = rd_hs;
        dat_d[0] = rd_word;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    // Pipeline registers. Data loads only with a valid entry, which makes
    // the output stage hold its last response between pulses. Reset drops
    // every in-flight read and clears the visible read data.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_q[i] <= 1'b0;
            end
            dat_q[RD_LAT-1] <= 32'd0;
        end else begin
            for (int i = 0; i < RD_LAT; i++) begin
                vld_q[i] <= vld_d[i];
                if (vld_d[i]) begin
                    dat_q[i] <= dat_d[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_sram_slave.sv
// Bench for mem_sram_slave: three instances with different latency and
// wait settings, checked cycle by cycle against a transaction-level model.
module tb_mem_sram_slave;
    localparam int N = 3;
    localparam int LAT [N] = '{1, 3, 2};
    localparam int WT  [N] = '{0, 0, 2};

    logic clk = 1'b0;
    logic rstb = 1'b0;
    always #5 clk = ~clk;

    logic        rdy  [N];
    logic        we   [N];
    logic [31:0] addr [N];
    logic [31:0] wd   [N];
    logic [3:0]  st   [N];
    logic        ov   [N];
    logic        orr  [N];
    logic        oerr [N];
    logic [31:0] ord  [N];

    mem_sram_slave_if bus [N] ();

    for (genvar g = 0; g < N; g++) begin : g_dut
        assign bus[g].mem_ready = rdy[g];
        assign bus[g].mem_we    = we[g];
        assign bus[g].mem_addr  = addr[g];
        assign bus[g].mem_wdata = wd[g];
        assign bus[g].mem_wstrb = st[g];
        assign ov[g]            = bus[g].mem_valid;
        assign orr[g]           = bus[g].mem_rresp;
        assign ord[g]           = bus[g].mem_rdata;
        assign oerr[g]          = bus[g].mem_err;

        mem_sram_slave #(.AW(10), .RD_LAT(LAT[g]), .WAIT_CYC(WT[g])) u_dut (
            .clk    (clk),
            .resetb (rstb),
            .mem    (bus[g])
        );
    end

    // Reference model: word array, ready-cycles served since last accept,
    // and a schedule of responses keyed by the cycle they are due.
    bit [31:0] mmem [N][1024];
    int        rcnt [N];
    bit        merr [N];
    bit [31:0] mrd  [N];
    bit        rv   [N][16];
    bit [31:0] rq   [N][16];
    bit        hs   [N];
    int        cyc;
    int        ntests;
    int        nfail;

    task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s u%0d cyc %0d: got %h expected %h", tag, k, cyc, obs, exp);
        end
    endtask

    // One clock: check every instance mid-cycle, then advance the model
    // through the coming edge.
    task automatic tick();
        bit        ev;
        bit        er;
        bit        oor;
        int        slot;
        logic [9:0] wi;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            ev   = rdy[k] && (rcnt[k] == WT[k]);
            slot = cyc % 16;
            er   = rv[k][slot];
            if (er) mrd[k] = rq[k][slot];
            rv[k][slot] = 1'b0;
            chk("mem_valid", k, 32'(ov[k]), 32'(ev));
            chk("mem_rresp", k, 32'(orr[k]), 32'(er));
            chk("mem_rdata", k, ord[k], mrd[k]);
            chk("mem_err", k, 32'(oerr[k]), 32'(merr[k]));
            hs[k] = ev && rstb;
            if (!rstb) begin
                for (int s = 0; s < 16; s++) rv[k][s] = 1'b0;
                mrd[k]  = 32'd0;
                merr[k] = 1'b0;
                rcnt[k] = 0;
            end else if (ev) begin
                oor = (addr[k][31:12] != 20'd0);
                wi  = addr[k][11:2];
                if (oor) merr[k] = 1'b1;
                if (we[k]) begin
                    if (!oor) begin
                        for (int b = 0; b < 4; b++)
                            if (st[k][b]) mmem[k][wi][8*b +: 8] = wd[k][8*b +: 8];
                    end
                end else begin
                    slot = (cyc + LAT[k]) % 16;
                    rv[k][slot] = 1'b1;
                    rq[k][slot] = oor ? 32'd0 : mmem[k][wi];
                end
                rcnt[k] = 0;
            end else if (rdy[k]) begin
                rcnt[k]++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic req(int k, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s);
        rdy[k] = 1'b1; we[k] = w; addr[k] = a; wd[k] = d; st[k] = s;
    endtask

    // Present a request and hold it until the model says it was accepted.
    task automatic xfer(int k, bit w, logic [31:0] a, logic [31:0] d, logic [3:0] s);
        bit done;
        done = 1'b0;
        req(k, w, a, d, s);
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            done = hs[k];
        end
        chk("accept", k, 32'(done), 32'd1);
    endtask

    task automatic idle_all();
        for (int k = 0; k < N; k++) rdy[k] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ntests = 0;
        nfail  = 0;
        cyc    = 0;
        for (int k = 0; k < N; k++) begin
            rdy[k] = 1'b0; we[k] = 1'b0; addr[k] = 32'd0; wd[k] = 32'd0; st[k] = 4'd0;
            hs[k] = 1'b0; rcnt[k] = 0; merr[k] = 1'b0; mrd[k] = 32'd0;
        end

        // Power-up reset, then observe the reset state.
        rstb = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rstb = 1'b1;
        tick();
        tick();

        // Preload words 0..15 of every instance; instance 1 gets 1,2,3 at words 0..2.
        for (int k = 0; k < N; k++) begin
            for (int w = 0; w < 16; w++) begin
                xfer(k, 1'b1, 32'(w << 2), (k == 1 && w < 3) ? 32'(w + 1) : $urandom, 4'hF);
            end
            idle_all();
            tick();
        end

        // Instance 0: write then read back, byte strobes, ignored low address bits.
        xfer(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
        xfer(0, 1'b0, 32'h100, 32'd0, 4'h0);
        xfer(0, 1'b1, 32'h0, 32'h00000000, 4'hF);
        xfer(0, 1'b1, 32'h0, 32'h11223344, 4'b0101);
        xfer(0, 1'b0, 32'h0, 32'd0, 4'h0);
        xfer(0, 1'b0, 32'h3, 32'd0, 4'h0);
        xfer(0, 1'b1, 32'h4, 32'hCAFEF00D, 4'h0);
        xfer(0, 1'b0, 32'h4, 32'd0, 4'h0);
        idle_all();
        tick();
        tick();
        chk("rdata_hold", 0, ord[0], mrd[0]);

        // Instance 0: out-of-range read, dropped out-of-range write, sticky error.
        xfer(0, 1'b0, 32'h00001000, 32'd0, 4'h0);
        idle_all();
        tick();
        tick();
        xfer(0, 1'b1, 32'h00001000, 32'h55, 4'hF);
        xfer(0, 1'b0, 32'h0, 32'd0, 4'h0);
        idle_all();
        repeat (3) tick();

        // Instance 1 (latency 3): back-to-back reads, then a write that must
        // not disturb the read already in flight.
        xfer(1, 1'b0, 32'h0, 32'd0, 4'h0);
        xfer(1, 1'b0, 32'h4, 32'd0, 4'h0);
        xfer(1, 1'b0, 32'h8, 32'd0, 4'h0);
        xfer(1, 1'b1, 32'h8, 32'h77, 4'hF);
        idle_all();
        repeat (4) tick();
        xfer(1, 1'b0, 32'h8, 32'd0, 4'h0);
        idle_all();
        repeat (4) tick();

        // Instance 2 (2 wait cycles): continuous request, then a request
        // that drops mid-wait and resumes without restarting the count.
        xfer(2, 1'b0, 32'h0, 32'd0, 4'h0);
        xfer(2, 1'b0, 32'h4, 32'd0, 4'h0);
        idle_all();
        tick();
        req(2, 1'b0, 32'h8, 32'd0, 4'h0);
        tick();
        rdy[2] = 1'b0;
        tick();
        tick();
        rdy[2] = 1'b1;
        tick();
        tick();
        chk("resume_accept", 2, 32'(hs[2]), 32'd1);
        idle_all();
        repeat (3) tick();

        // Reset with a read in flight: no late response, data cleared,
        // array contents kept.
        xfer(2, 1'b1, 32'h14, 32'hA5A50F0F, 4'hF);
        xfer(2, 1'b0, 32'h0, 32'd0, 4'h0);
        idle_all();
        rstb = 1'b0;
        tick();
        rstb = 1'b1;
        repeat (4) tick();
        xfer(2, 1'b0, 32'h14, 32'd0, 4'h0);
        idle_all();
        repeat (3) tick();

        // Randomised traffic on all instances, including out-of-range
        // addresses and requests changed or withdrawn while waiting.
        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < N; k++) begin
                if (hs[k] || !rdy[k] || ($urandom_range(0, 5) == 0)) begin
                    rdy[k]  = ($urandom_range(0, 3) != 0);
                    we[k]   = 1'($urandom_range(0, 1));
                    addr[k] = 32'(($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
                    if ($urandom_range(0, 15) == 0)
                        addr[k] = addr[k] | (32'h1000 << $urandom_range(0, 19));
                    wd[k] = $urandom;
                    st[k] = 4'($urandom_range(0, 15));
                end
            end
            tick();
        end
        idle_all();
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
